// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes,
// FSM states, operation kinds and small decode helpers.
package muldiv_pkg;

  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_MUL_S = 2'd0,
    OP_MUL_U = 2'd1,
    OP_DIV_S = 2'd2,
    OP_DIV_U = 2'd3
  } op_t;

  function automatic logic is_muldiv(input logic [FUNCT_W-1:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  // Only meaningful when is_muldiv(funct) is true.
  function automatic op_t decode_op(input logic [FUNCT_W-1:0] funct);
    op_t op;
    case (funct)
      FUNCT_MULT:  op = OP_MUL_S;
      FUNCT_MULTU: op = OP_MUL_U;
      FUNCT_DIV:   op = OP_DIV_S;
      default:     op = OP_DIV_U;
    endcase
    return op;
  endfunction

  function automatic logic op_is_div(input op_t op);
    return (op == OP_DIV_S) || (op == OP_DIV_U);
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return (op == OP_MUL_S) || (op == OP_DIV_S);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic [FUNCT_W-1:0] funct_i;
  logic [WIDTH-1:0]   src_a_i;
  logic [WIDTH-1:0]   src_b_i;
  logic               flush_i;
  logic               busy_o;
  logic               done_o;
  logic               div_by_zero_o;
  logic [WIDTH-1:0]   hi_o;
  logic [WIDTH-1:0]   lo_o;

  modport master (
    output start_i, funct_i, src_a_i, src_b_i, flush_i,
    input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, funct_i, src_a_i, src_b_i, flush_i,
    output busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration of shift-add multiply or restoring divide.
// Multiply: acc = {partial product high, remaining multiplier bits}.
// Divide:   acc = {partial remainder, dividend bits / quotient bits};
// the new quotient bit is shifted into acc[0].
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_q_bit;

  // Compute both candidate next-accumulators and select by operation.
  always_comb begin
    w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
                (i_acc[0] ? {1'b0, i_operand} : '0);
    w_shifted = i_acc[2*WIDTH-1:WIDTH-1];
    w_diff    = w_shifted - {1'b0, i_operand};
    w_q_bit   = ~w_diff[WIDTH];
    if (i_is_div) begin
      o_acc = {(w_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0]),
               i_acc[WIDTH-2:0], w_q_bit};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: IDLE -> RUN (WIDTH steps) -> SIGN,
// with MTHI/MTLO writes handled directly from IDLE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     resetn,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [CW-1:0]      r_cnt;
  op_t                r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_raw_a;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz_out;

  op_t                w_op;
  logic               w_idle_req;
  logic               w_accept;
  logic               w_mt_write;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_step_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Request decode; a flush in IDLE discards any start in the same cycle.
  assign w_idle_req = (r_state == ST_IDLE) && bus.start_i && !bus.flush_i;
  assign w_op       = decode_op(bus.funct_i);
  assign w_accept   = w_idle_req && is_muldiv(bus.funct_i);
  assign w_mt_write = w_idle_req &&
                      ((bus.funct_i == FUNCT_MTHI) || (bus.funct_i == FUNCT_MTLO));
  assign w_a_neg    = op_is_signed(w_op) && bus.src_a_i[WIDTH-1];
  assign w_b_neg    = op_is_signed(w_op) && bus.src_b_i[WIDTH-1];
  assign w_abs_a    = w_a_neg ? -bus.src_a_i : bus.src_a_i;
  assign w_abs_b    = w_b_neg ? -bus.src_b_i : bus.src_b_i;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div  (op_is_div(r_op)),
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .o_acc     (w_step_acc)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; flush abandons RUN/SIGN without touching HI/LO.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_RUN;
      ST_RUN: begin
        if (bus.flush_i)                     w_state_next = ST_IDLE;
        else if (r_cnt == CW'(WIDTH - 1))    w_state_next = ST_SIGN;
      end
      ST_SIGN: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sign correction of the raw magnitude results, plus divide-by-zero override.
  always_comb begin
    w_prod   = r_neg_res ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (op_is_div(r_op)) begin
      if (r_dbz) begin
        w_res_hi = r_raw_a;
        w_res_lo = '1;
      end else begin
        w_res_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_res_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Operand latches, iteration, HI/LO registers and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_op      <= OP_MUL_S;
      r_acc     <= '0;
      r_operand <= '0;
      r_raw_a   <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      r_busy    <= (w_state_next != ST_IDLE);
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
      if (w_accept) begin
        r_op      <= w_op;
        r_acc     <= {{WIDTH{1'b0}}, (op_is_div(w_op) ? w_abs_a : w_abs_b)};
        r_operand <= op_is_div(w_op) ? w_abs_b : w_abs_a;
        r_raw_a   <= bus.src_a_i;
        r_neg_res <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_dbz     <= op_is_div(w_op) && (bus.src_b_i == '0);
        r_cnt     <= '0;
      end
      if (w_mt_write) begin
        if (bus.funct_i == FUNCT_MTHI) r_hi <= bus.src_a_i;
        else                           r_lo <= bus.src_a_i;
      end
      if (r_state == ST_RUN) begin
        r_acc <= w_step_acc;
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == ST_SIGN) && !bus.flush_i) begin
        r_hi      <= w_res_hi;
        r_lo      <= w_res_lo;
        r_done    <= 1'b1;
        r_dbz_out <= r_dbz;
      end
    end
  end

  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.div_by_zero_o = r_dbz_out;
  assign bus.hi_o          = r_hi;
  assign bus.lo_o          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32;
  exp_t e8;

  muldiv_if #(.WIDTH(32)) bus32 ();
  muldiv_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .resetn(resetn), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .resetn(resetn), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Monitors: pop and compare whenever a done pulse appears.
  always @(negedge clk) begin
    if (bus32.done_o === 1'b1) begin
      if (q32.size() == 0) begin
        chk("w32_unexpected_done", 64'd1, 64'd0);
      end else begin
        e32 = q32.pop_front();
        $display("w32 done cyc=%0d hi=%08h lo=%08h dbz=%0b", cyc, bus32.hi_o, bus32.lo_o, bus32.div_by_zero_o);
        chk("w32_hi", 64'(bus32.hi_o), 64'(e32.hi));
        chk("w32_lo", 64'(bus32.lo_o), 64'(e32.lo));
        chk("w32_dbz", 64'(bus32.div_by_zero_o), 64'(e32.dbz));
        chk("w32_latency", 64'(cyc), 64'(e32.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (bus8.done_o === 1'b1) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 64'd1, 64'd0);
      end else begin
        e8 = q8.pop_front();
        $display("w8 done cyc=%0d hi=%02h lo=%02h dbz=%0b", cyc, bus8.hi_o, bus8.lo_o, bus8.div_by_zero_o);
        chk("w8_hi", 64'(bus8.hi_o), 64'(e8.hi));
        chk("w8_lo", 64'(bus8.lo_o), 64'(e8.lo));
        chk("w8_dbz", 64'(bus8.div_by_zero_o), 64'(e8.dbz));
        chk("w8_latency", 64'(cyc), 64'(e8.cyc));
      end
    end
  end

  // Drive a request for one cycle; returns 1 ns after the accepting edge.
  task automatic issue32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus32.start_i = 1'b1;
    bus32.funct_i = f;
    bus32.src_a_i = a;
    bus32.src_b_i = b;
    @(posedge clk);
    #1;
    bus32.start_i = 1'b0;
  endtask

  task automatic issue8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.start_i = 1'b1;
    bus8.funct_i = f;
    bus8.src_a_i = a;
    bus8.src_b_i = b;
    @(posedge clk);
    #1;
    bus8.start_i = 1'b0;
  endtask

  // Called in cycle T+1: result due WIDTH+1 cycles later.
  task automatic expect32(input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dbz = dbz; e.cyc = cyc + 33;
    q32.push_back(e);
  endtask

  task automatic expect8(input logic [7:0] hi, input logic [7:0] lo, input logic dbz);
    exp_t e;
    e.hi = 32'(hi); e.lo = 32'(lo); e.dbz = dbz; e.cyc = cyc + 9;
    q8.push_back(e);
  endtask

  task automatic wait_idle32();
    int n = 0;
    while (bus32.busy_o !== 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w32_idle_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (bus8.busy_o !== 1'b0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w8_idle_timeout", 64'(n < 200), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus32.start_i = 1'b0; bus32.flush_i = 1'b0; bus32.funct_i = '0;
    bus32.src_a_i = '0;   bus32.src_b_i = '0;
    bus8.start_i = 1'b0;  bus8.flush_i = 1'b0;  bus8.funct_i = '0;
    bus8.src_a_i = '0;    bus8.src_b_i = '0;
    #23;
    chk("reset_busy", 64'(bus32.busy_o), 64'd0);
    chk("reset_done", 64'(bus32.done_o), 64'd0);
    chk("reset_dbz", 64'(bus32.div_by_zero_o), 64'd0);
    chk("reset_hi", 64'(bus32.hi_o), 64'd0);
    chk("reset_lo", 64'(bus32.lo_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // 1: MULT -2 * 3, busy window and latency
    issue32(FUNCT_MULT, 32'hFFFF_FFFE, 32'd3);
    expect32(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    chk("t1_busy_T+1", 64'(bus32.busy_o), 64'd1);
    repeat (32) @(posedge clk);
    #1;
    chk("t1_busy_T+33", 64'(bus32.busy_o), 64'd1);
    @(posedge clk);
    #1;
    chk("t1_busy_T+34", 64'(bus32.busy_o), 64'd0);

    // 2: unsigned and signed truncating divide
    issue32(FUNCT_DIVU, 32'd100, 32'd7);
    expect32(32'd2, 32'd14, 1'b0);
    wait_idle32();
    issue32(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    expect32(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_idle32();

    // 3: signed overflow, divide by zero
    issue32(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    expect32(32'd0, 32'h8000_0000, 1'b0);
    wait_idle32();
    issue32(FUNCT_DIVU, 32'h1234, 32'd0);
    expect32(32'h1234, 32'hFFFF_FFFF, 1'b1);
    wait_idle32();

    // 4: preload, flush-in-idle discard, flush mid-RUN, restart
    issue32(FUNCT_MTHI, 32'hAA, 32'd0);
    chk("t4_mthi", 64'(bus32.hi_o), 64'hAA);
    issue32(FUNCT_MTLO, 32'h55, 32'd0);
    chk("t4_mtlo", 64'(bus32.lo_o), 64'h55);
    @(negedge clk);
    bus32.flush_i = 1'b1;
    issue32(FUNCT_MTLO, 32'h77, 32'd0);
    bus32.flush_i = 1'b0;
    chk("t4_flush_idle_lo", 64'(bus32.lo_o), 64'h55);
    chk("t4_flush_idle_busy", 64'(bus32.busy_o), 64'd0);
    issue32(FUNCT_MULTU, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    bus32.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus32.flush_i = 1'b0;
    chk("t4_busy_after_flush", 64'(bus32.busy_o), 64'd0);
    chk("t4_hi_kept", 64'(bus32.hi_o), 64'hAA);
    chk("t4_lo_kept", 64'(bus32.lo_o), 64'h55);
    issue32(FUNCT_DIVU, 32'd1000, 32'd33);
    expect32(32'd10, 32'd30, 1'b0);
    wait_idle32();

    // 5: start while busy ignored, MTHI, async reset mid-RUN
    issue32(FUNCT_MULT, 32'd5, 32'hFFFF_FFFD);
    expect32(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    repeat (4) @(negedge clk);
    bus32.start_i = 1'b1;
    bus32.funct_i = FUNCT_MULT;
    bus32.src_a_i = 32'd7;
    bus32.src_b_i = 32'd7;
    @(posedge clk);
    #1;
    bus32.start_i = 1'b0;
    wait_idle32();
    issue32(FUNCT_MTHI, 32'hDEAD, 32'd0);
    chk("t5_mthi", 64'(bus32.hi_o), 64'hDEAD);
    chk("t5_mthi_no_done", 64'(bus32.done_o), 64'd0);
    chk("t5_mthi_no_busy", 64'(bus32.busy_o), 64'd0);
    issue32(FUNCT_MULTU, 32'd3, 32'd3);
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(bus32.busy_o), 64'd0);
    chk("t5_rst_hi", 64'(bus32.hi_o), 64'd0);
    chk("t5_rst_lo", 64'(bus32.lo_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // 6: WIDTH=8 instance
    issue8(FUNCT_MULTU, 8'hFF, 8'hFF);
    expect8(8'hFE, 8'h01, 1'b0);
    wait_idle8();
    issue8(FUNCT_DIV, 8'h80, 8'hFF);
    expect8(8'h00, 8'h80, 1'b0);
    wait_idle8();

    repeat (5) @(posedge clk);
    #1;
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the MIPS execute stage, servicing the HI/LO class of R-type `funct` codes that the combinational ALU decode path does not cover. It accepts a decoded `funct` plus two operands, runs a radix-2 shift-add or restoring-divide loop over `WIDTH` cycles, applies sign correction, and holds the results in architectural HI/LO registers. The stall logic uses `busy_o` to freeze the pipeline while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Must be an even number, 4 or greater.
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous, active-low reset
- `start_i`  in  1  request valid, sampled on a rising edge
- `funct_i`  in  6  MIPS funct: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011
- `src_a_i`  in  WIDTH  multiplicand/dividend, or the MTHI/MTLO data
- `src_b_i`  in  WIDTH  multiplier/divisor
- `flush_i`  in  1  exception flush; aborts any in-flight operation
- `busy_o`  out  1  operation in flight; `start_i` is ignored while high
- `done_o`  out  1  one-cycle pulse when HI/LO carry a new mul/div result
- `div_by_zero_o`  out  1  qualifies `done_o`; high when the completed divide had `src_b`=0
- `hi_o`  out  WIDTH  HI register
- `lo_o`  out  WIDTH  LO register

## Operation
- **States:** IDLE, RUN, SIGN.
- **Reset values:** all outputs are 0; the state is IDLE.
- **IDLE**
  - `start_i` with a mul/div funct: latch |a| and |b|, the sign flags and the op kind; clear the counter; go to RUN.
  - Signed ops take absolute values. Unsigned ops take the operands raw.
  - MTHI/MTLO: on the edge, `hi_o` or `lo_o` ← `src_a_i`. The state stays IDLE, and neither `busy_o` nor `done_o` asserts.
  - Any other funct: no effect.
- **RUN:** one bit per cycle for exactly `WIDTH` cycles. The counter is $clog2(WIDTH)+1 bits wide.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring step; the partial remainder is WIDTH+1 bits.
- **SIGN:** one cycle, then write HI/LO, pulse `done_o`, return to IDLE.
  - Product: negate when the operand signs differ (signed ops only).
  - Quotient: negate when the signs differ. Remainder takes the sign of the dividend (truncating division).
- **Division by zero (both signed and unsigned):**
  - `lo_o` = all ones, `hi_o` = raw `src_a_i` as latched.
  - `div_by_zero_o`=1 with `done_o`.
  - Full latency is kept.
- **Signed overflow** (−2^(W−1) / −1): `lo_o` = 10…0, `hi_o` = 0. No flag.
- **Flush**
  - In RUN or SIGN: go to IDLE on the next edge. HI/LO are not written and `done_o` does not pulse.
  - In IDLE: a `start_i` in the same cycle is discarded, including MTHI/MTLO.
- **Start while busy:** ignored. The requester holds `start_i` until it is accepted.
- **Reset mid-operation:** state, HI, LO and all outputs go to 0 immediately (asynchronous).

## Timing
- A start is accepted at the edge ending cycle T. RUN occupies T+1…T+WIDTH, and SIGN occupies T+WIDTH+1.
- `busy_o`, registered: high in cycles T+1…T+WIDTH+1.
- `done_o`, `div_by_zero_o` and the new HI/LO are visible in cycle T+WIDTH+2, the same cycle `busy_o` falls.
  - A new start may be accepted in that cycle.
  - Total latency is WIDTH+2: 34 cycles for WIDTH=32.
- MTHI/MTLO is visible in cycle T+1.
- `flush_i` in cycle F (F in RUN/SIGN): `busy_o` is low in F+1.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- **`muldiv_pkg`:** funct localparams (MULT, MULTU, DIV, DIVU, MTHI, MTLO), the state enum, the op-kind enum (MUL/DIV, signed/unsigned). The shared decode defines header mirrors these funct codes.
- **`muldiv_step` sub-module:** combinational single-iteration datapath. It takes the accumulator/remainder and the operand and produces the next accumulator and quotient bit for mul or div.
- **Top level:** owns the FSM, counter, operand/sign latches, sign correction and the HI/LO registers.

## Test plan
All scenarios use WIDTH=32 unless stated otherwise.
1. MULT a=0xFFFFFFFE, b=3, start at T → `done_o` at T+34, `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFFA; `busy_o` high T+1…T+33.
2. DIVU 100/7 → `lo_o`=14, `hi_o`=2. DIV 0xFFFFFFF9/2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF.
3. Divide corner cases:
   - DIV 0x80000000/0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0, `div_by_zero_o`=0.
   - DIVU 0x1234/0 → `lo_o`=0xFFFFFFFF, `hi_o`=0x1234, `div_by_zero_o`=1 with `done_o`.
4. HI/LO preloaded 0xAA/0x55, MULTU started, `flush_i` at T+10 → `busy_o`=0 at T+11; no `done_o`; HI/LO stay 0xAA/0x55; a DIVU start at T+11 completes at T+45.
5. Start of a second MULT at T+5 while busy → ignored, only one `done_o`. Then:
   - MTHI 0xDEAD in IDLE → `hi_o`=0xDEAD next cycle, no `done_o`.
   - `resetn` low mid-RUN → `busy_o`, `hi_o`, `lo_o` = 0 without a clock edge.
6. WIDTH=8: MULTU 0xFF×0xFF → `done_o` at T+10, `hi_o`=0xFE, `lo_o`=0x01. DIV 0x80/0xFF → `lo_o`=0x80, `hi_o`=0.
